// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//   Owns a WIDTH-bit up/down counter and runs programmed bursts: each pass
//   counts from cfg_first to cfg_last (modulo 2^WIDTH), and the pass is
//   repeated cfg_reps times (0 is treated as 1). All outputs are registered.
//
//   Optional feature macro: COUNTER_SEQ_PAUSE_EN
//     When defined, adds a 'pause' input that freezes the counter, the
//     repetition count and the state while in RUN. abort is still honoured.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   start      begin a burst (IDLE only; ignored while busy)
//   abort      terminate the active burst; overrides start in IDLE
//   cfg_first  first count value of each pass
//   cfg_last   last count value of each pass
//   cfg_dir    0 = count up, 1 = count down
//   cfg_reps   number of passes (0 -> 1)
//   pause      (COUNTER_SEQ_PAUSE_EN only) stall RUN
//   Q          counter value
//   busy       high in LOAD, RUN and DONE
//   pass_done  one-cycle pulse at end of each pass
//   done       one-cycle pulse at end of the burst
//   reps_left  passes remaining, including the current one
// ---------------------------------------------------------------------------
module counter_sequencer #(
   parameter int WIDTH  = 3,
   parameter int REPS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  cfg_first,
   input  logic [WIDTH-1:0]  cfg_last,
   input  logic              cfg_dir,
   input  logic [REPS_W-1:0] cfg_reps,
`ifdef COUNTER_SEQ_PAUSE_EN
   input  logic              pause,
`endif
   output logic [WIDTH-1:0]  Q,
   output logic              busy,
   output logic              pass_done,
   output logic              done,
   output logic [REPS_W-1:0] reps_left
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t              state, state_n;
   logic [WIDTH-1:0]    first_r, last_r, q_n;
   logic                dir_r;
   logic [REPS_W-1:0]   reps_r, reps_n;
   logic                pd_n, dn_n, latch;
   logic                stall;

`ifdef COUNTER_SEQ_PAUSE_EN
   assign stall = pause;
`else
   assign stall = 1'b0;
`endif

   // State, counter, outputs and the burst configuration snapshot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         Q         <= '0;
         reps_left <= '0;
         busy      <= 1'b0;
         pass_done <= 1'b0;
         done      <= 1'b0;
         first_r   <= '0;
         last_r    <= '0;
         dir_r     <= 1'b0;
         reps_r    <= '0;
      end else begin
         state     <= state_n;
         Q         <= q_n;
         reps_left <= reps_n;
         busy      <= (state_n != S_IDLE);
         pass_done <= pd_n;
         done      <= dn_n;
         // Snapshot so later cfg_* changes cannot disturb the running burst.
         if (latch) begin
            first_r <= cfg_first;
            last_r  <= cfg_last;
            dir_r   <= cfg_dir;
            reps_r  <= cfg_reps;
         end
      end
   end

   always_comb begin
      state_n = state;
      q_n     = Q;
      reps_n  = reps_left;
      pd_n    = 1'b0;
      dn_n    = 1'b0;
      latch   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               latch   = 1'b1;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_n = S_IDLE;
            end else begin
               q_n     = first_r;
               reps_n  = (reps_r == '0) ? REPS_W'(1) : reps_r;
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            // abort wins over a pass/burst end landing in the same cycle.
            if (abort) begin
               state_n = S_IDLE;
            end else if (!stall) begin
               if (Q != last_r) begin
                  q_n = dir_r ? Q - 1'b1 : Q + 1'b1;
               end else if (reps_left > REPS_W'(1)) begin
                  q_n    = first_r;
                  reps_n = reps_left - 1'b1;
                  pd_n   = 1'b1;
               end else begin
                  // Final pass: Q holds last through DONE and afterwards.
                  reps_n  = '0;
                  pd_n    = 1'b1;
                  dn_n    = 1'b1;
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, cfg_dir = 1'b0, pause = 1'b0;
   logic [2:0] cfg_first = '0, cfg_last = '0;
   logic [3:0] cfg_reps = '0;
   logic [2:0] q;
   logic       busy, pass_done, done;
   logic [3:0] reps_left;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   counter_sequencer #(.WIDTH(3), .REPS_W(4)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_first (cfg_first),
      .cfg_last  (cfg_last),
      .cfg_dir   (cfg_dir),
      .cfg_reps  (cfg_reps),
`ifdef COUNTER_SEQ_PAUSE_EN
      .pause     (pause),
`endif
      .Q         (q),
      .busy      (busy),
      .pass_done (pass_done),
      .done      (done),
      .reps_left (reps_left)
   );

   // One record = inputs held across one rising edge + outputs expected after it.
   typedef struct {
      string      name;
      logic       st, ab, dir, pz;
      logic [2:0] f, l;
      logic [3:0] r;
      logic [2:0] eq;
      logic       eb, ep, ed;
      logic [3:0] erl;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string name, logic st, logic ab, logic [2:0] f,
                               logic [2:0] l, logic dir, logic [3:0] r, logic pz,
                               logic [2:0] eq, logic eb, logic ep, logic ed,
                               logic [3:0] erl);
      vec_t v;
      v.name = name; v.st = st; v.ab = ab; v.f = f; v.l = l; v.dir = dir;
      v.r = r; v.pz = pz; v.eq = eq; v.eb = eb; v.ep = ep; v.ed = ed; v.erl = erl;
      return v;
   endfunction

   task automatic check(string name, logic [2:0] eq, logic eb, logic ep,
                        logic ed, logic [3:0] erl);
      n_tests++;
      if ({q, busy, pass_done, done, reps_left} !== {eq, eb, ep, ed, erl}) begin
         n_fail++;
         $display("FAIL %s: got Q=%0d busy=%0b pd=%0b done=%0b rl=%0d, want Q=%0d busy=%0b pd=%0b done=%0b rl=%0d",
                  name, q, busy, pass_done, done, reps_left, eq, eb, ep, ed, erl);
      end
   endtask

   task automatic apply(vec_t v);
      start = v.st; abort = v.ab; cfg_first = v.f; cfg_last = v.l;
      cfg_dir = v.dir; cfg_reps = v.r; pause = v.pz;
      @(posedge clk);
      #1;
      check(v.name, v.eq, v.eb, v.ep, v.ed, v.erl);
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) apply(tbl[i]);
      tbl.delete();
   endtask

   initial begin
      // Reset state, checked before any clock edge.
      #2;
      check("reset_state", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //                 name          st ab f  l  d  r  pz  eq b pd dn rl
      // Up single pass 2..5; cfg scrambled after start to prove the snapshot.
      tbl.push_back(mk("up_load",     1, 0, 2, 5, 0, 1, 0,  0, 1, 0, 0, 0));
      tbl.push_back(mk("up_q2",       0, 0, 7, 7, 1, 9, 0,  2, 1, 0, 0, 1));
      tbl.push_back(mk("up_q3",       0, 0, 7, 7, 1, 9, 0,  3, 1, 0, 0, 1));
      tbl.push_back(mk("up_q4",       0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0, 1));
      tbl.push_back(mk("up_q5",       0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 1));
      tbl.push_back(mk("up_done",     0, 0, 0, 0, 0, 0, 0,  5, 1, 1, 1, 0));
      tbl.push_back(mk("up_idle",     0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0));
      tbl.push_back(mk("up_hold",     0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0));
      // Down with wrap 1..6, two passes; start held high while busy is ignored.
      tbl.push_back(mk("dn_load",     1, 0, 1, 6, 1, 2, 0,  5, 1, 0, 0, 0));
      tbl.push_back(mk("dn_q1",       1, 0, 1, 6, 1, 2, 0,  1, 1, 0, 0, 2));
      tbl.push_back(mk("dn_q0",       1, 0, 3, 3, 0, 5, 0,  0, 1, 0, 0, 2));
      tbl.push_back(mk("dn_q7",       1, 0, 3, 3, 0, 5, 0,  7, 1, 0, 0, 2));
      tbl.push_back(mk("dn_q6",       1, 0, 3, 3, 0, 5, 0,  6, 1, 0, 0, 2));
      tbl.push_back(mk("dn_p2_q1",    1, 0, 3, 3, 0, 5, 0,  1, 1, 1, 0, 1));
      tbl.push_back(mk("dn_p2_q0",    1, 0, 3, 3, 0, 5, 0,  0, 1, 0, 0, 1));
      tbl.push_back(mk("dn_p2_q7",    1, 0, 3, 3, 0, 5, 0,  7, 1, 0, 0, 1));
      tbl.push_back(mk("dn_p2_q6",    1, 0, 3, 3, 0, 5, 0,  6, 1, 0, 0, 1));
      tbl.push_back(mk("dn_done",     1, 0, 3, 3, 0, 5, 0,  6, 1, 1, 1, 0));
      tbl.push_back(mk("dn_idle",     1, 0, 3, 3, 0, 5, 0,  6, 0, 0, 0, 0));
      // reps=0 behaves as reps=1.
      tbl.push_back(mk("r0_load",     1, 0, 3, 4, 0, 0, 0,  6, 1, 0, 0, 0));
      tbl.push_back(mk("r0_q3",       0, 0, 3, 4, 0, 0, 0,  3, 1, 0, 0, 1));
      tbl.push_back(mk("r0_q4",       0, 0, 3, 4, 0, 0, 0,  4, 1, 0, 0, 1));
      tbl.push_back(mk("r0_done",     0, 0, 3, 4, 0, 0, 0,  4, 1, 1, 1, 0));
      tbl.push_back(mk("r0_idle",     0, 0, 3, 4, 0, 0, 0,  4, 0, 0, 0, 0));
      // first==last, three one-cycle passes.
      tbl.push_back(mk("eq_load",     1, 0, 4, 4, 0, 3, 0,  4, 1, 0, 0, 0));
      tbl.push_back(mk("eq_p1",       0, 0, 4, 4, 0, 3, 0,  4, 1, 0, 0, 3));
      tbl.push_back(mk("eq_p2",       0, 0, 4, 4, 0, 3, 0,  4, 1, 1, 0, 2));
      tbl.push_back(mk("eq_p3",       0, 0, 4, 4, 0, 3, 0,  4, 1, 1, 0, 1));
      tbl.push_back(mk("eq_done",     0, 0, 4, 4, 0, 3, 0,  4, 1, 1, 1, 0));
      tbl.push_back(mk("eq_idle",     0, 0, 4, 4, 0, 3, 0,  4, 0, 0, 0, 0));
      // Abort at Q=3 in a 0..7 pass: Q and reps_left hold, no done.
      tbl.push_back(mk("ab_load",     1, 0, 0, 7, 0, 1, 0,  4, 1, 0, 0, 0));
      tbl.push_back(mk("ab_q0",       0, 0, 0, 7, 0, 1, 0,  0, 1, 0, 0, 1));
      tbl.push_back(mk("ab_q1",       0, 0, 0, 7, 0, 1, 0,  1, 1, 0, 0, 1));
      tbl.push_back(mk("ab_q2",       0, 0, 0, 7, 0, 1, 0,  2, 1, 0, 0, 1));
      tbl.push_back(mk("ab_q3",       0, 0, 0, 7, 0, 1, 0,  3, 1, 0, 0, 1));
      tbl.push_back(mk("ab_abort",    0, 1, 0, 7, 0, 1, 0,  3, 0, 0, 0, 1));
      tbl.push_back(mk("ab_stay",     0, 0, 0, 7, 0, 1, 0,  3, 0, 0, 0, 1));
      // start+abort in IDLE stays IDLE.
      tbl.push_back(mk("stab_idle",   1, 1, 1, 2, 0, 1, 0,  3, 0, 0, 0, 1));
      tbl.push_back(mk("stab_idle2",  1, 1, 1, 2, 0, 1, 0,  3, 0, 0, 0, 1));
      // Abort in LOAD.
      tbl.push_back(mk("abl_load",    1, 0, 6, 6, 0, 2, 0,  3, 1, 0, 0, 1));
      tbl.push_back(mk("abl_abort",   0, 1, 6, 6, 0, 2, 0,  3, 0, 0, 0, 1));
      // Abort on the final-pass end cycle: no pass_done, no done.
      tbl.push_back(mk("abe_load",    1, 0, 2, 2, 0, 1, 0,  3, 1, 0, 0, 1));
      tbl.push_back(mk("abe_q2",      0, 0, 2, 2, 0, 1, 0,  2, 1, 0, 0, 1));
      tbl.push_back(mk("abe_abort",   0, 1, 2, 2, 0, 1, 0,  2, 0, 0, 0, 1));
      run_tbl();

      // Async reset mid-RUN, between clock edges.
      tbl.push_back(mk("ar_load",     1, 0, 0, 7, 0, 2, 0,  2, 1, 0, 0, 1));
      tbl.push_back(mk("ar_q0",       0, 0, 0, 7, 0, 2, 0,  0, 1, 0, 0, 2));
      tbl.push_back(mk("ar_q1",       0, 0, 0, 7, 0, 2, 0,  1, 1, 0, 0, 2));
      run_tbl();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tbl.push_back(mk("post_rst1",   0, 0, 0, 7, 0, 2, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("post_rst2",   0, 0, 0, 7, 0, 2, 0,  0, 0, 0, 0, 0));
      run_tbl();

`ifdef COUNTER_SEQ_PAUSE_EN
      // Pause at Q=1 for 3 cycles: done arrives 3 cycles late.
      tbl.push_back(mk("pz_load",     1, 0, 0, 3, 0, 1, 0,  0, 1, 0, 0, 0));
      tbl.push_back(mk("pz_q0",       0, 0, 0, 3, 0, 1, 0,  0, 1, 0, 0, 1));
      tbl.push_back(mk("pz_q1",       0, 0, 0, 3, 0, 1, 0,  1, 1, 0, 0, 1));
      tbl.push_back(mk("pz_hold1",    0, 0, 0, 3, 0, 1, 1,  1, 1, 0, 0, 1));
      tbl.push_back(mk("pz_hold2",    0, 0, 0, 3, 0, 1, 1,  1, 1, 0, 0, 1));
      tbl.push_back(mk("pz_hold3",    0, 0, 0, 3, 0, 1, 1,  1, 1, 0, 0, 1));
      tbl.push_back(mk("pz_q2",       0, 0, 0, 3, 0, 1, 0,  2, 1, 0, 0, 1));
      tbl.push_back(mk("pz_q3",       0, 0, 0, 3, 0, 1, 0,  3, 1, 0, 0, 1));
      tbl.push_back(mk("pz_done",     0, 0, 0, 3, 0, 1, 0,  3, 1, 1, 1, 0));
      tbl.push_back(mk("pz_idle",     0, 0, 0, 3, 0, 1, 0,  3, 0, 0, 0, 0));
      // Pause on Q==last suppresses pass_done until released.
      tbl.push_back(mk("pzl_load",    1, 0, 2, 2, 0, 1, 0,  3, 1, 0, 0, 0));
      tbl.push_back(mk("pzl_q2",      0, 0, 2, 2, 0, 1, 0,  2, 1, 0, 0, 1));
      tbl.push_back(mk("pzl_hold",    0, 0, 2, 2, 0, 1, 1,  2, 1, 0, 0, 1));
      tbl.push_back(mk("pzl_done",    0, 0, 2, 2, 0, 1, 0,  2, 1, 1, 1, 0));
      tbl.push_back(mk("pzl_idle",    0, 0, 2, 2, 0, 1, 0,  2, 0, 0, 0, 0));
      // abort honoured while paused.
      tbl.push_back(mk("pza_load",    1, 0, 5, 7, 0, 1, 0,  2, 1, 0, 0, 0));
      tbl.push_back(mk("pza_q5",      0, 0, 5, 7, 0, 1, 0,  5, 1, 0, 0, 1));
      tbl.push_back(mk("pza_abort",   0, 1, 5, 7, 0, 1, 1,  5, 0, 0, 0, 1));
      run_tbl();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
